// File: rtl/mem_resp_pkg.sv
// Shared encodings and widths for the wait-state memory responder.
// Used by mem_wait_responder and mem_resp_array.
package mem_resp_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_resp_array.sv
// DEPTH x 32 word store: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[idx] <= wd;
    end
  end

  assign rd = r_mem[idx];

endmodule

// File: rtl/mem_wait_responder.sv
// Word-addressed memory responder: one request at a time, LATENCY edges to a one-cycle ack.
// Optional misalignment check enabled by defining MEM_RESP_ALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | ready; a request level on an edge is accepted (also the ack cycle)
// WAIT  | counting wait states
// RESP  | last wait cycle; the edge leaving it raises ack and commits a write
module mem_wait_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        mem_err
);

  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(LATENCY - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [ADDR_W-1:0]   r_idx;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_is_write;
  logic                r_misalign;

  logic                w_req;
  logic                w_accept;
  logic                w_misalign_in;
  logic                w_we;
  logic [DATA_W-1:0]   w_rd;
  logic                w_unused_addr;

  logic                w_ack_nxt;
  logic                w_busy_nxt;
  logic                w_err_nxt;
  logic [DATA_W-1:0]   w_rdata_nxt;
  logic                r_ack;
  logic                r_busy;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;

  assign w_req    = mem_read | mem_write;
  assign w_accept = (r_state == IDLE) && w_req;

`ifdef MEM_RESP_ALIGN_CHECK_EN
  assign w_misalign_in = |addr[1:0];
`else
  assign w_misalign_in = 1'b0;
`endif

  // Upper address bits alias onto the array; byte-offset bits only matter with the check.
  assign w_unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_idx      <= addr[ADDR_W+1:2];
        r_wdata    <= wdata;
        r_is_write <= mem_write;
        r_misalign <= w_misalign_in;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == LAT_LAST) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // The write lands on the same edge that raises ack, so any later read sees it.
  always_comb begin
    w_we        = (r_state == RESP) && r_is_write && !r_misalign;
    w_ack_nxt   = (r_state == RESP);
    w_busy_nxt  = (r_state != IDLE) || w_accept;
    w_err_nxt   = (r_state == RESP) && r_misalign;
    w_rdata_nxt = '0;
    if ((r_state == RESP) && !r_is_write && !r_misalign) begin
      w_rdata_nxt = w_rd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_ack_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_err_nxt;
      r_rdata <= w_rdata_nxt;
    end
  end

  mem_resp_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk(clk),
    .we (w_we),
    .idx(r_idx),
    .wd (r_wdata),
    .rd (w_rd)
  );

  assign ack     = r_ack;
  assign busy    = r_busy;
  assign mem_err = r_err;
  assign rdata   = r_rdata;

endmodule

// File: tb/tb_mem_wait_responder.sv
// Scoreboard bench for mem_wait_responder: requests push expected acks, a monitor pops on ack.
// Honours MEM_RESP_ALIGN_CHECK_EN for the misaligned-write case.
module tb_mem_wait_responder;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ack;
  logic        busy;
  logic        mem_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          ack_cyc;
  } exp_t;

  exp_t q[$];
  logic prev_ack = 1'b0;

  mem_wait_responder #(
    .ADDR_W (8),
    .LATENCY(LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ack      (ack),
    .busy     (busy),
    .mem_err  (mem_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (ack) begin
        check("ack_width", {31'b0, prev_ack}, 32'h0);
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ack: ack at cycle %0d with nothing pending", cyc);
        end else begin
          e = q.pop_front();
          check("rdata", rdata, e.data);
          check("mem_err", {31'b0, mem_err}, {31'b0, e.err});
          check("ack_cycle", cyc, e.ack_cyc);
        end
      end else begin
        check("rdata_no_ack", rdata, 32'h0);
      end
    end
    prev_ack = ack;
  end

  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e);
    int   nb;
    exp_t e;
    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = wd;
    e.data    = exp_d;
    e.err     = exp_e;
    e.ack_cyc = cyc + 1 + LAT;
    q.push_back(e);
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    nb = 0;
    while (busy && nb < 40) begin
      nb++;
      @(negedge clk);
    end
    check("busy_cycles", nb, LAT + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int nb;
    exp_t e;

    repeat (2) @(negedge clk);
    #1;
    check("reset_ack", {31'b0, ack}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_err", {31'b0, mem_err}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Basic write then read of word 4
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Write then read same word: first ack shows rdata 0
    do_req(1'b0, 1'b1, 32'h20, 32'h12345678, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0);

    // Read level held 12 cycles: accepts every LAT+1 edges
    @(negedge clk);
    mem_read = 1'b1;
    addr     = 32'h10;
    base     = cyc;
    for (int k = 0; k < 3; k++) begin
      e.data    = 32'hDEADBEEF;
      e.err     = 1'b0;
      e.ack_cyc = base + 1 + LAT + k * (LAT + 1);
      q.push_back(e);
    end
    repeat (12) @(negedge clk);
    mem_read = 1'b0;
    nb = 0;
    while (busy && nb < 40) begin
      nb++;
      @(negedge clk);
    end
    check("held_busy_drop", {31'b0, busy}, 32'h0);
    check("held_queue", q.size(), 32'h0);

    // Reset in the middle of a write's wait states
    do_req(1'b0, 1'b1, 32'h8, 32'h11112222, 32'h0, 1'b0);
    @(negedge clk);
    mem_write = 1'b1;
    addr      = 32'h8;
    wdata     = 32'hFFFFFFFF;
    @(negedge clk);
    mem_write = 1'b0;
    check("busy_pre_reset", {31'b0, busy}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check("midreset_busy", {31'b0, busy}, 32'h0);
    check("midreset_ack", {31'b0, ack}, 32'h0);
    check("midreset_rdata", rdata, 32'h0);
    check("midreset_err", {31'b0, mem_err}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    do_req(1'b1, 1'b0, 32'h8, 32'h0, 32'h11112222, 1'b0);

    // Misaligned write to word 1
    do_req(1'b0, 1'b1, 32'h4, 32'h01010101, 32'h0, 1'b0);
`ifdef MEM_RESP_ALIGN_CHECK_EN
    do_req(1'b0, 1'b1, 32'h6, 32'hCAFEF00D, 32'h0, 1'b1);
    do_req(1'b1, 1'b0, 32'h4, 32'h0, 32'h01010101, 1'b0);
`else
    do_req(1'b0, 1'b1, 32'h6, 32'hCAFEF00D, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 32'h4, 32'h0, 32'hCAFEF00D, 1'b0);
`endif

    // Read+write together acts as write; aliasing of high address bits
    do_req(1'b1, 1'b1, 32'h0, 32'hA5A5A5A5, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0);
    do_req(1'b1, 1'b0, 32'h400, 32'h0, 32'hA5A5A5A5, 1'b0);
    do_req(1'b1, 1'b0, 32'h00AB0010, 32'h0, 32'hDEADBEEF, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_empty", q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
